mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file and consumes its two read ports (rs value, rt value) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Results are held in HI/LO for later MFHI/MFLO.
- While busy, the pipeline control stalls any further mult/div/HI-LO instruction.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state changes occur on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  operation request; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
- rs_data  input  WIDTH  register read_data1 (multiplicand/dividend/MTxx source).
- rt_data  input  WIDTH  register read_data2 (multiplier/divisor).
- flush  input  1  synchronous cancel of an in-flight operation.
- busy  output  1  operation in progress; request stall.
- done  output  1  one-cycle pulse when HI/LO are updated by a mult/div.
- hi  output  WIDTH  HI register (MFHI source).
- lo  output  WIDTH  LO register (MFLO source).

Behaviour:
- Reset (rst_n=0, asynchronous): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- States:
  - IDLE: wait for a request.
  - CALC: exactly WIDTH iterations, one per clock.
  - FIX: sign correction and HI/LO writeback.
- IDLE, start=1 with op MULT/MULTU/DIV/DIVU, at edge N:
  - Capture magnitudes of the operands: absolute value for signed ops, raw value for unsigned.
  - Record result signs.
  - Set counter=0, busy=1, state=CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, edges N+1..N+WIDTH. Counter increments each step; leave CALC after counter reaches WIDTH-1.
- FIX, edge N+WIDTH+1:
  - Negate the product if the operand signs differ.
  - Quotient sign = sign(rs) XOR sign(rt).
  - Remainder sign = sign(rs).
  - Write hi/lo, done=1 for exactly one cycle, busy=0, state=IDLE.
- Total: busy high for WIDTH+1 cycles; done high in the cycle after edge N+WIDTH+1.
- Multiply result: hi = product[2*WIDTH-1:WIDTH], lo = product[WIDTH-1:0].
- Divide result: lo = quotient, hi = remainder.
- Divide by zero: no trap. lo = all ones, hi = rs_data, same latency.
- Signed overflow (rs = 0x80000000, rt = 0xFFFFFFFF, DIV): lo = 0x80000000, hi = 0.
- MTHI/MTLO in IDLE: hi (or lo) = rs_data at that edge. busy stays 0, done stays 0, the other register is unchanged.
- start while busy=1: ignored completely. Producer must hold the request until busy=0.
- Undefined op codes: no state change.
- flush=1 in CALC or FIX: at that edge state=IDLE, busy=0, done=0, hi/lo keep their pre-operation values.
- flush has priority over a FIX writeback in the same edge.
- flush in IDLE has priority over start: the request is dropped.
- Reset mid-operation: immediate return to the reset values, no partial result written.
- hi/lo change only at FIX writeback, at MTHI/MTLO, or at reset. They are stable during CALC, so MFHI/MFLO reads are consistent.
- A new start is accepted in the same cycle done=1, since busy=0 then.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> after 33 busy cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Check busy is exactly 33 cycles and done is exactly 1 cycle.
- DIV checks:
  - rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next edge, lo unchanged, busy and done stay 0. MTLO issued while busy -> ignored, lo unchanged after done.
- Preload hi=0xAAAA0000, lo=0x0000BBBB, start MULT, assert flush at cycle 10 -> busy=0 next edge, no done, hi/lo still 0xAAAA0000/0x0000BBBB.
- Async reset:
  - Drop rst_n mid-CALC, between clock edges -> busy=0, hi=0, lo=0 immediately.
  - Release, issue MULTU 3x5 -> lo=15, hi=0.
  - Back-to-back start asserted on the done cycle is accepted.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fix-up at the end.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             is_div_q, is_div_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic             div0_q, div0_d;
   logic             done_q, done_d;

   logic             rs_neg, rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod, prod_fix;

   always_comb begin
      rs_neg = ~op[0] & rs_data[WIDTH-1];
      rt_neg = ~op[0] & rt_data[WIDTH-1];
      rs_mag = rs_neg ? (~rs_data + WIDTH'(1)) : rs_data;
      rt_mag = rt_neg ? (~rt_data + WIDTH'(1)) : rt_data;
      // acc holds the running high half (multiply) or partial remainder (divide)
      mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      div_shift = {acc_q, q_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      prod      = {acc_q, q_q};
      prod_fix  = neg_lo_q ? (~prod + (2*WIDTH)'(1)) : prod;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      q_d      = q_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      div0_d   = div0_q;
      done_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start && !flush) begin
               case (op)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     acc_d    = '0;
                     q_d      = rs_mag;
                     b_d      = rt_mag;
                     is_div_d = op[1];
                     neg_lo_d = rs_neg ^ rt_neg;
                     neg_hi_d = rs_neg;
                     div0_d   = op[1] & (rt_data == '0);
                     cnt_d    = '0;
                     state_d  = StCalc;
                  end
                  3'b100:  hi_d = rs_data;
                  3'b101:  lo_d = rs_data;
                  default: ;
               endcase
            end
         end
         StCalc: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               if (is_div_q) begin
                  if (!div_diff[WIDTH]) begin
                     acc_d = div_diff[WIDTH-1:0];
                     q_d   = {q_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_d = div_shift[WIDTH-1:0];
                     q_d   = {q_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_d = mul_sum[WIDTH:1];
                  q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!flush) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  // divide by zero yields all-ones quotient; remainder path already equals rs
                  lo_d = div0_q ? '1 : (neg_lo_q ? (~q_q + WIDTH'(1)) : q_q);
                  hi_d = neg_hi_q ? (~acc_q + WIDTH'(1)) : acc_q;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         q_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         div0_q   <= div0_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized bench for mult_div_unit with a queue scoreboard of expected HI/LO.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b111;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad = 0;
   logic [63:0] exp_q[$];

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_data(rs_data),
      .rt_data(rt_data), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Independent arithmetic model of HI/LO results.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, sq, sr;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (o)
         3'd0: return sa * sb;
         3'd1: return {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Call at a negedge with busy=0; returns just after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
      if (o <= 3'd3) exp_q.push_back(exp);
      op = o; rs_data = a; rt_data = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; op = 3'b111;
   endtask

   task automatic wait_result(input bit chk_busy, input bit chk_pulse);
      int cyc = 0;
      bit seen = 0;
      logic [63:0] e;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) cyc++;
      end
      check("done_seen", 64'(seen), 64'd1);
      if (chk_busy) check("busy_cycles", 64'(cyc), 64'd33);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      check("hi", 64'(hi), 64'(e[63:32]));
      check("lo", 64'(lo), 64'(e[31:0]));
      if (chk_pulse) begin
         @(negedge clk);
         check("done_one_cycle", 64'(done), 64'd0);
         check("busy_after", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      bit          saw_done;
      #12;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      @(negedge clk) issue(3'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
      wait_result(1, 1);
      @(negedge clk) issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      wait_result(1, 1);
      @(negedge clk) issue(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      wait_result(1, 1);
      @(negedge clk) issue(3'd3, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
      wait_result(1, 1);
      @(negedge clk) issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      wait_result(1, 1);

      for (int k = 0; k < 6; k++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = (k == 2) ? 32'd0 : $urandom;
         @(negedge clk) issue(ro, ra, rb, model(ro, ra, rb));
         wait_result(1, 0);
      end

      // MTHI in idle: hi loads, lo and handshake untouched
      ra = lo;
      @(negedge clk) issue(3'd4, 32'h1234_5678, 32'd0, 64'd0);
      check("mthi_hi", 64'(hi), 64'h1234_5678);
      check("mthi_lo", 64'(lo), 64'(ra));
      check("mthi_busy", 64'(busy), 64'd0);
      check("mthi_done", 64'(done), 64'd0);

      // MTLO while busy must be ignored
      @(negedge clk) issue(3'd1, 32'd3, 32'd5, 64'd15);
      repeat (3) @(negedge clk);
      op = 3'd5; rs_data = 32'hDEAD_BEEF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; op = 3'b111;
      wait_result(0, 1);

      // flush mid-CALC keeps preloaded HI/LO, no done
      @(negedge clk) issue(3'd4, 32'hAAAA_0000, 32'd0, 64'd0);
      @(negedge clk) issue(3'd5, 32'h0000_BBBB, 32'd0, 64'd0);
      @(negedge clk) issue(3'd0, 32'd1234, 32'd5678, 64'd0);
      exp_q.delete();
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      saw_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      check("flush_no_done", 64'(saw_done), 64'd0);
      check("flush_hi", 64'(hi), 64'hAAAA_0000);
      check("flush_lo", 64'(lo), 64'h0000_BBBB);

      // asynchronous reset between edges mid-CALC
      @(negedge clk) issue(3'd0, 32'd99, 32'd77, 64'd0);
      exp_q.delete();
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_hi", 64'(hi), 64'd0);
      check("arst_lo", 64'(lo), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      @(negedge clk) issue(3'd1, 32'd3, 32'd5, 64'd15);
      wait_result(1, 0);
      // back-to-back: start on the done cycle
      issue(3'd1, 32'd2, 32'd7, 64'd14);
      check("b2b_busy", 64'(busy), 64'd1);
      wait_result(0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
